// File: rtl/spi_adc_responder.sv
// spi_adc_responder: SPI mode-0 peripheral emulating a serial ADC.
// Buffers parallel samples in a FIFO and shifts one out MSB-first per chip-select frame.
module spi_adc_responder #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FIFO_DEPTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_SAMPLE = '0
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid_in,
    output logic                          sample_ready_out,
    input  logic                          chip_clk_in,
    input  logic                          chip_sel_in,
    output logic                          chip_data_out,
    output logic                          frame_done_out,
    output logic                          underrun_out,
    output logic                          abort_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync;
    logic                   r_sclk_prev, r_cs_prev;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   w_push, w_pop, w_empty;
    state_t                 r_state, w_state_n;
    logic [DATA_WIDTH-1:0]  r_shift, w_shift_n;
    logic [CW-1:0]          r_cnt, w_cnt_n;
    logic                   r_done, r_under, r_abort, w_done_n, w_under_n, w_abort_n;
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], chip_clk_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], chip_sel_in};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end
    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
    assign sample_ready_out = r_count != (AW+1)'(FIFO_DEPTH);
    assign fifo_count_out   = r_count;
    assign w_empty          = r_count == '0;
    assign w_push           = sample_valid_in & sample_ready_out;
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= sample_in;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // A rise that completes the frame takes priority over a simultaneous CS rise.
    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;
        w_under_n = 1'b0;
        w_abort_n = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: if (w_cs_fall) begin
                w_shift_n = w_empty ? IDLE_SAMPLE : r_mem[r_rd_ptr];
                w_pop     = !w_empty;
                w_under_n = w_empty;
                w_cnt_n   = '0;
                w_state_n = SHIFT;
            end
            SHIFT: begin
                if (w_sclk_rise && r_cnt != CW'(DATA_WIDTH)) w_cnt_n = r_cnt + CW'(1);
                if (w_sclk_fall && r_cnt != CW'(DATA_WIDTH)) w_shift_n = {r_shift[DATA_WIDTH-2:0], 1'b0};
                if (w_cnt_n == CW'(DATA_WIDTH)) begin
                    w_done_n  = 1'b1;
                    w_state_n = w_cs_rise ? IDLE : HOLD;
                end else if (w_cs_rise) begin
                    w_abort_n = 1'b1;
                    w_state_n = IDLE;
                end
            end
            HOLD: if (w_cs_rise) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_under <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
            r_done  <= w_done_n;
            r_under <= w_under_n;
            r_abort <= w_abort_n;
        end
    end
    assign chip_data_out  = (r_state == SHIFT) & r_shift[DATA_WIDTH-1];
    assign frame_done_out = r_done;
    assign underrun_out   = r_under;
    assign abort_out      = r_abort;
endmodule

// File: tb/tb_spi_adc_responder.sv
// tb_spi_adc_responder: directed scenario tests for spi_adc_responder.
module tb_spi_adc_responder;
    localparam int HP = 6;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid_in = 1'b0;
    logic        sample_ready_out;
    logic        chip_clk_in = 1'b0;
    logic        chip_sel_in = 1'b1;
    logic        chip_data_out, frame_done_out, underrun_out, abort_out;
    logic [4:0]  fifo_count_out;
    int total = 0, bad = 0;
    int n_done = 0, n_under = 0, n_abort = 0;

    spi_adc_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in),
        .sample_valid_in(sample_valid_in), .sample_ready_out(sample_ready_out),
        .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in), .chip_data_out(chip_data_out),
        .frame_done_out(frame_done_out), .underrun_out(underrun_out), .abort_out(abort_out),
        .fifo_count_out(fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_done_out === 1'b1) n_done++;
        if (underrun_out === 1'b1) n_under++;
        if (abort_out === 1'b1) n_abort++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] v);
        sample_in = v;
        sample_valid_in = 1'b1;
        tick(1);
        sample_valid_in = 1'b0;
    endtask

    task automatic spi_frame(input int rises, output logic [15:0] d);
        d = '0;
        chip_sel_in = 1'b0;
        tick(8);
        for (int i = 0; i < rises; i++) begin
            d = {d[14:0], chip_data_out};
            chip_clk_in = 1'b1;
            tick(HP);
            chip_clk_in = 1'b0;
            tick(HP);
        end
        chip_sel_in = 1'b1;
        tick(8);
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        tick(3);
        rst_in = 1'b1;
        tick(2);
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count_out); end
        total++; if (sample_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sample_ready_out); end
        total++; if (chip_data_out !== 1'b0) begin bad++; $display("FAIL reset_data got=%b want=0", chip_data_out); end
        total++; if (n_done + n_under + n_abort !== 0) begin bad++; $display("FAIL reset_pulses got=%0d want=0", n_done + n_under + n_abort); end
    endtask

    task automatic test_single;
        logic [15:0] d;
        int bd, bu, ba;
        push(16'hA5C3);
        total++; if (fifo_count_out !== 5'd1) begin bad++; $display("FAIL single_count_pre got=%0d want=1", fifo_count_out); end
        bd = n_done; bu = n_under; ba = n_abort;
        spi_frame(16, d);
        total++; if (d !== 16'hA5C3) begin bad++; $display("FAIL single_data got=%h want=a5c3", d); end
        total++; if (n_done - bd !== 1) begin bad++; $display("FAIL single_done got=%0d want=1", n_done - bd); end
        total++; if (n_under - bu + n_abort - ba !== 0) begin bad++; $display("FAIL single_other got=%0d want=0", n_under - bu + n_abort - ba); end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL single_count_post got=%0d want=0", fifo_count_out); end
    endtask

    task automatic test_order;
        logic [15:0] d;
        logic [15:0] exp_v [3] = '{16'h0001, 16'h8000, 16'h7FFF};
        int bd, bu;
        for (int i = 0; i < 3; i++) push(exp_v[i]);
        bd = n_done; bu = n_under;
        for (int i = 0; i < 3; i++) begin
            spi_frame(16, d);
            total++; if (d !== exp_v[i]) begin bad++; $display("FAIL order_data%0d got=%h want=%h", i, d, exp_v[i]); end
        end
        total++; if (n_under - bu !== 0) begin bad++; $display("FAIL order_underrun got=%0d want=0", n_under - bu); end
        total++; if (n_done - bd !== 3) begin bad++; $display("FAIL order_done got=%0d want=3", n_done - bd); end
    endtask

    task automatic test_underrun;
        logic [15:0] d;
        int bd, bu;
        bd = n_done; bu = n_under;
        spi_frame(16, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL underrun_data got=%h want=0000", d); end
        total++; if (n_under - bu !== 1) begin bad++; $display("FAIL underrun_pulse got=%0d want=1", n_under - bu); end
        total++; if (n_done - bd !== 1) begin bad++; $display("FAIL underrun_done got=%0d want=1", n_done - bd); end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL underrun_count got=%0d want=0", fifo_count_out); end
    endtask

    task automatic test_overflow;
        logic [15:0] d;
        int bu;
        for (int i = 0; i < 16; i++) push(16'(i));
        total++; if (sample_ready_out !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b want=0", sample_ready_out); end
        total++; if (fifo_count_out !== 5'd16) begin bad++; $display("FAIL ovf_count_full got=%0d want=16", fifo_count_out); end
        push(16'd16);
        total++; if (fifo_count_out !== 5'd16) begin bad++; $display("FAIL ovf_count_drop got=%0d want=16", fifo_count_out); end
        bu = n_under;
        for (int i = 0; i < 16; i++) begin
            spi_frame(16, d);
            total++; if (d !== 16'(i)) begin bad++; $display("FAIL ovf_data%0d got=%h want=%h", i, d, 16'(i)); end
        end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL ovf_count_end got=%0d want=0", fifo_count_out); end
        total++; if (n_under - bu !== 0) begin bad++; $display("FAIL ovf_underrun got=%0d want=0", n_under - bu); end
    endtask

    task automatic test_abort;
        logic [15:0] d;
        int bd, ba;
        push(16'hFFFF);
        push(16'h1234);
        bd = n_done; ba = n_abort;
        spi_frame(7, d);
        total++; if (d !== 16'h007F) begin bad++; $display("FAIL abort_bits got=%h want=007f", d); end
        total++; if (n_abort - ba !== 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", n_abort - ba); end
        total++; if (n_done - bd !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", n_done - bd); end
        total++; if (chip_data_out !== 1'b0) begin bad++; $display("FAIL abort_data_low got=%b want=0", chip_data_out); end
        spi_frame(16, d);
        total++; if (d !== 16'h1234) begin bad++; $display("FAIL abort_next got=%h want=1234", d); end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL abort_count got=%0d want=0", fifo_count_out); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        int b_all, bd, bu;
        push(16'h5555);
        push(16'h6666);
        chip_sel_in = 1'b0;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            chip_clk_in = 1'b1;
            tick(HP);
            chip_clk_in = 1'b0;
            tick(HP);
        end
        b_all = n_done + n_under + n_abort;
        chip_sel_in = 1'b1;
        rst_in = 1'b0;
        tick(1);
        rst_in = 1'b1;
        tick(8);
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", fifo_count_out); end
        total++; if (chip_data_out !== 1'b0) begin bad++; $display("FAIL rstmid_data got=%b want=0", chip_data_out); end
        total++; if (n_done + n_under + n_abort - b_all !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d want=0", n_done + n_under + n_abort - b_all); end
        bd = n_done; bu = n_under;
        spi_frame(16, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL rstmid_next got=%h want=0000", d); end
        total++; if (n_under - bu !== 1) begin bad++; $display("FAIL rstmid_underrun got=%0d want=1", n_under - bu); end
        total++; if (n_done - bd !== 1) begin bad++; $display("FAIL rstmid_done got=%0d want=1", n_done - bd); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_underrun();
        test_overflow();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- Peripheral end of the ADC SPI link: emulates the serial ADC read by the sonar's SPI controllers.
- Buffers parallel samples in a FIFO; pops one per chip-select frame and shifts it out MSB-first on the data line.
- Used for on-FPGA loopback and bench emulation of echo waveforms without the analog front end.

Parameters:
- DATA_WIDTH, 16, bits per frame and per sample.
- FIFO_DEPTH, 16, sample buffer entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in each synchronizer on chip_clk_in and chip_sel_in; at least 2.
- IDLE_SAMPLE, 16'h0000, value shifted when the FIFO is empty at frame start.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous, active-low reset.
- sample_in  input  DATA_WIDTH  sample to enqueue.
- sample_valid_in  input  1  enqueue request.
- sample_ready_out  output  1  high when the FIFO is not full.
- chip_clk_in  input  1  SPI clock from the controller; idles low.
- chip_sel_in  input  1  chip select, active low.
- chip_data_out  output  1  serial data to the controller.
- frame_done_out  output  1  one-cycle pulse when all DATA_WIDTH bits have been sampled.
- underrun_out  output  1  one-cycle pulse when a frame starts with the FIFO empty.
- abort_out  output  1  one-cycle pulse when CS deasserts before the frame completes.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_in==0 at posedge):
  - FIFO is emptied; fifo_count_out=0; sample_ready_out=1.
  - chip_data_out=0; all pulse outputs are 0; FSM goes to IDLE.
  - Synchronizer flops load the idle levels: chip_clk 0, chip_sel 1.
  - Reset mid-frame discards the frame and any FIFO contents; no pulse is emitted.
- Synchronization:
  - chip_clk_in and chip_sel_in each pass through SYNC_STAGES flops, then a registered edge detector.
  - Each edge is acted on SYNC_STAGES+1 cycles after it occurs at the pin.
  - The controller's SPI clock half-period must be at least SYNC_STAGES+3 clk_in cycles.
- FIFO:
  - Push when sample_valid_in && sample_ready_out. A push while full is dropped and the count is unchanged.
  - Pop occurs only at frame start.
  - Push and pop in the same cycle: both take effect; count unchanged; the popped entry is the old head.
  - A push into an empty FIFO is visible to a pop on the next cycle, not the same cycle.
- FSM states: IDLE, SHIFT, HOLD.
  - IDLE: chip_data_out=0.
    - On a synced CS fall: load the shift register with the FIFO head and pop.
    - If the FIFO is empty: load IDLE_SAMPLE, do not pop, pulse underrun_out.
    - Drive chip_data_out = bit DATA_WIDTH-1 in the same cycle as the load. Set bit_cnt=0. Go to SHIFT.
  - SHIFT:
    - Synced SCLK rise: bit_cnt++. If bit_cnt reaches DATA_WIDTH, pulse frame_done_out and go to HOLD.
    - Synced SCLK fall: shift left by one and drive the next MSB. A fall at or after the last rise does not shift.
    - Synced CS rise before DATA_WIDTH rises: pulse abort_out, chip_data_out=0, go to IDLE. The popped sample is lost.
  - HOLD:
    - chip_data_out=0; SCLK edges are ignored.
    - Synced CS rise: go to IDLE, no pulse.
  - CS rise and SCLK rise in the same synced cycle while in SHIFT: the rise counts first. If it completes the frame, pulse frame_done_out only and go to IDLE; otherwise pulse abort_out.
- Mode 0: the controller samples on SCLK rising edges, and data is stable from frame start or from the prior fall.
- bit_cnt wraps never: its width is $clog2(DATA_WIDTH)+1 and it saturates at DATA_WIDTH.
- Pulse outputs are mutually exclusive per frame, except that underrun_out may precede either frame_done_out or abort_out.

Test Plan:
- Push 16'hA5C3, then run a 16-clock frame with half-period 6 -> controller sees 16'hA5C3 MSB-first; frame_done_out pulses once; fifo_count_out goes 1->0.
- Push 16'h0001, 16'h8000, 16'h7FFF; run three frames -> the reads return them in order; no underrun_out.
- FIFO empty, run a frame -> reads IDLE_SAMPLE 16'h0000; underrun_out pulses once at frame start; count stays 0.
- Push 17 samples (0..16) with no frames -> sample_ready_out drops after 16; the 17th is dropped; count=16; subsequent reads return 0..15.
- Push 16'hFFFF; deassert CS after 7 SCLK rises -> abort_out pulses; no frame_done_out; chip_data_out=0; the next frame reads the next FIFO entry.
- Mid-SHIFT, hold rst_in=0 for one cycle -> count=0, chip_data_out=0, no pulses; the next frame reads IDLE_SAMPLE with underrun_out.
